// File: rtl/fp_addsub_param.sv
// fp_addsub_param: multi-cycle floating-point adder/subtractor with
// round-to-nearest-even, subnormal flush-to-zero and exception flags.
// One operation in flight; start/done handshake.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] sum,
    output logic                 done,
    output logic                 busy,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 5;   // {carry, hidden, frac, G, R, S}
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EXP_W-1:0] DMAX = EXP_W'(MAN_W + 2);
    localparam logic [EXP_W:0]   ONE  = (EXP_W+1)'(1);
    localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic           sign_q, sign_d, sub_q, sub_d;
    logic [EXP_W:0] exp_q, exp_d;
    logic [SW-1:0]  ml_q, ml_d, ms_q, ms_d;
    logic [W-1:0]   sum_q, sum_d, res_c;
    logic [3:0]     flags_q, flags_d, flg_c;
    logic           done_q, done_d, busy_q, busy_d;

    // Operand fields (b already carries the op-adjusted sign)
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign {sa, ea, fa} = opa_q;
    assign {sb, eb, fb} = opb_q;
    assign nan_a  = (ea == EMAX) && (fa != '0);
    assign nan_b  = (eb == EMAX) && (fb != '0);
    assign inf_a  = (ea == EMAX) && (fa == '0);
    assign inf_b  = (eb == EMAX) && (fb == '0);
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);

    // Alignment: larger magnitude by {exp,frac}, smaller shifted right with sticky
    logic             a_big, sl, ss;
    logic [EXP_W-1:0] el, es, dexp;
    logic [MAN_W-1:0] fl, fs;
    logic [SW-1:0]    sig_s, sig_sh, lost;

    assign a_big  = {ea, fa} >= {eb, fb};
    assign {sl, el, fl} = a_big ? opa_q : opb_q;
    assign {ss, es, fs} = a_big ? opb_q : opa_q;
    assign dexp   = el - es;
    assign sig_s  = {2'b01, fs, 3'b000};
    assign sig_sh = sig_s >> dexp;
    assign lost   = sig_s & ~({SW{1'b1}} << dexp);

    // Significand add/subtract (L >= S, so subtraction never goes negative)
    logic [SW-1:0] add_res;
    assign add_res = sub_q ? (ml_q - ms_q) : (ml_q + ms_q);

    // Round to nearest even on G/R/S
    logic             g, r, st, inc, rcarry, rhid;
    logic [MAN_W+1:0] rnd;
    logic [EXP_W:0]   exp_r;

    assign {g, r, st} = ml_q[2:0];
    assign inc    = g & (r | st | ml_q[3]);
    assign rnd    = {1'b0, ml_q[SW-2:3]} + (MAN_W+2)'(inc);
    assign rcarry = rnd[MAN_W+1];
    assign rhid   = rcarry | rnd[MAN_W];
    assign exp_r  = exp_q + (EXP_W+1)'(rcarry);

    // Next-state, datapath and result selection
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        exp_d   = exp_q;
        ml_d    = ml_q;
        ms_d    = ms_q;
        sum_d   = sum_q;
        flags_d = flags_q;
        busy_d  = busy_q;
        res_c   = '0;
        flg_c   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b ^ {op, {(W-1){1'b0}}};
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_DONE;
                if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
                    res_c = QNAN;
                    flg_c = 4'b1000;
                end else if (inf_a)           res_c = opa_q;
                else if (inf_b)               res_c = opb_q;
                else if (zero_a && zero_b)    res_c = {sa & sb, {(W-1){1'b0}}};
                else if (zero_a)              res_c = opb_q;
                else if (zero_b)              res_c = opa_q;
                else                          state_d = S_ALIGN;
            end
            S_ALIGN: begin
                sign_d  = sl;
                sub_d   = sl ^ ss;
                exp_d   = {1'b0, el};
                ml_d    = {2'b01, fl, 3'b000};
                ms_d    = (dexp > DMAX) ? SW'(1) : (sig_sh | SW'(|lost));
                state_d = S_ADD;
            end
            S_ADD: begin
                if (add_res == '0) begin
                    state_d = S_DONE;   // exact cancellation gives +0
                end else begin
                    ml_d    = add_res;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (ml_q[SW-1]) begin
                    ml_d    = {1'b0, ml_q[SW-1:2], ml_q[1] | ml_q[0]};
                    exp_d   = exp_q + ONE;
                    state_d = S_ROUND;
                end else if (ml_q[SW-2] || exp_q == ONE) begin
                    state_d = S_ROUND;
                end else begin
                    ml_d  = ml_q << 1;
                    exp_d = exp_q - ONE;
                end
            end
            S_ROUND: begin
                state_d = S_DONE;
                if (!rhid) begin
                    res_c = {sign_q, {(W-1){1'b0}}};
                    flg_c = 4'b0011;
                end else if (exp_r >= {1'b0, EMAX}) begin
                    res_c = {sign_q, EMAX, {MAN_W{1'b0}}};
                    flg_c = 4'b0101;
                end else begin
                    res_c = {sign_q, exp_r[EXP_W-1:0], rnd[MAN_W-1:0]};
                    flg_c = {3'b000, g | r | st};
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE && state_q != S_DONE) begin
            sum_d   = res_c;
            flags_d = flg_c;
        end
        done_d = (state_d == S_DONE);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_q   <= '0;
            opb_q   <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= '0;
            ml_q    <= '0;
            ms_q    <= '0;
            sum_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            exp_q   <= exp_d;
            ml_q    <= ml_d;
            ms_q    <= ms_d;
            sum_q   <= sum_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sum   = sum_q;
    assign flags = flags_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule
